// File: rtl/tank_sprite_fetch.sv
// Tank layer sprite fetch: box hit test, rotated ROM addressing,
// tread animation and a 2-Clk pipeline to the tank palette.
module tank_sprite_fetch #(
    parameter int          SIZE        = 32,
    parameter int          ANIM_TICKS  = 8,
    parameter logic [3:0]  TRANSPARENT = 4'h0,
    parameter int          ADDR_W      = 11
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        TankX,
    input  logic [9:0]        TankY,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        index,
    output logic              sprite_on,
    output logic              anim_frame
);

    localparam int LOG = $clog2(SIZE);
    localparam int CW  = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ANIM_TICKS - 1);

    logic [9:0]        sx, sy, sx_n, sy_n;
    logic [1:0]        sdir, dir_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              anim_n;
    logic [10:0]       dx, dy;
    logic              hit, hit_d1, hit_d2;
    logic [LOG-1:0]    u, v;
    logic [ADDR_W-1:0] addr_n;

    // A pixel coincident with frame_tick already sees the new shadow state.
    always_comb begin
        sx_n   = frame_tick ? TankX : sx;
        sy_n   = frame_tick ? TankY : sy;
        dir_n  = frame_tick ? dir : sdir;
        cnt_n  = cnt;
        anim_n = anim_frame;
        if (frame_tick && moving) begin
            if (cnt == LAST) begin
                cnt_n  = '0;
                anim_n = ~anim_frame;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    // 11-bit differences keep a box near the right edge from wrapping.
    always_comb begin
        dx  = {1'b0, DrawX} - {1'b0, sx_n};
        dy  = {1'b0, DrawY} - {1'b0, sy_n};
        hit = (DrawX >= sx_n) && (dx < 11'(SIZE)) &&
              (DrawY >= sy_n) && (dy < 11'(SIZE));
        u = dx[LOG-1:0];
        v = dy[LOG-1:0];
        unique case (dir_n)
            2'd0: begin
                u = ~dy[LOG-1:0];
                v = dx[LOG-1:0];
            end
            2'd1: begin
                u = dx[LOG-1:0];
                v = dy[LOG-1:0];
            end
            2'd2: begin
                u = dy[LOG-1:0];
                v = ~dx[LOG-1:0];
            end
            2'd3: begin
                u = ~dx[LOG-1:0];
                v = dy[LOG-1:0];
            end
        endcase
        addr_n = hit ? ADDR_W'({anim_n, v, u}) : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sx         <= '0;
            sy         <= '0;
            sdir       <= 2'd1;
            cnt        <= '0;
            anim_frame <= 1'b0;
            rom_addr   <= '0;
            hit_d1     <= 1'b0;
            hit_d2     <= 1'b0;
            index      <= 4'h0;
            sprite_on  <= 1'b0;
        end else begin
            sx         <= sx_n;
            sy         <= sy_n;
            sdir       <= dir_n;
            cnt        <= cnt_n;
            anim_frame <= anim_n;
            rom_addr   <= addr_n;
            hit_d1     <= hit;
            hit_d2     <= hit_d1;
            index      <= hit_d2 ? rom_q : 4'h0;
            sprite_on  <= hit_d2 && (rom_q != TRANSPARENT);
        end
    end

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Directed bench for tank_sprite_fetch with a synchronous ROM model
// whose content is rom[a] = a[3:0] + 1 (so address 15 is transparent).
module tb_tank_sprite_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [9:0]  draw_x, draw_y, tank_x, tank_y;
    logic [1:0]  dir;
    logic        moving;
    logic [10:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  index;
    logic        sprite_on;
    logic        anim_frame;

    int tests = 0;
    int fails = 0;

    tank_sprite_fetch dut (
        .Clk        (clk),
        .Reset      (rst),
        .frame_tick (frame_tick),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .TankX      (tank_x),
        .TankY      (tank_y),
        .dir        (dir),
        .moving     (moving),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .index      (index),
        .sprite_on  (sprite_on),
        .anim_frame (anim_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_addr[3:0] + 4'd1;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        tank_x     = '0;
        tank_y     = '0;
        dir        = 2'd1;
        moving     = 1'b0;
        step(3);
        check("rst_addr", rom_addr, 0);
        check("rst_index", index, 0);
        check("rst_sprite_on", sprite_on, 0);
        check("rst_anim", anim_frame, 0);
        rst = 1'b0;

        tank_x = 10'd100;
        tank_y = 10'd50;
        tick();
        draw_x = 10'd100;
        draw_y = 10'd50;
        step();
        check("corner_addr", rom_addr, 0);
        step(2);
        check("corner_index", index, 1);
        check("corner_on", sprite_on, 1);

        draw_x = 10'd132;
        step();
        check("x132_addr", rom_addr, 0);
        step(2);
        check("x132_on", sprite_on, 0);
        check("x132_index", index, 0);

        draw_x = 10'd115;
        step();
        check("transp_addr", rom_addr, 15);
        step(2);
        check("transp_on", sprite_on, 0);

        draw_x = 10'd103;
        draw_y = 10'd55;
        step();
        check("right_addr", rom_addr, 163);
        step(2);
        check("right_index", index, 4);
        check("right_on", sprite_on, 1);
        dir = 2'd3;
        tick();
        check("left_addr", rom_addr, 188);
        dir = 2'd0;
        tick();
        check("up_addr", rom_addr, 122);
        dir = 2'd2;
        tick();
        check("down_addr", rom_addr, 901);
        dir = 2'd1;
        tick();
        check("back_right", rom_addr, 163);

        draw_x = 10'd100;
        draw_y = 10'd50;
        moving = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            step();
        end
        check("anim_7", anim_frame, 0);
        check("anim_7_addr", rom_addr, 0);
        tick();
        check("anim_8", anim_frame, 1);
        check("anim_8_addr", rom_addr, 1024);
        step(2);
        check("anim_8_index", index, 1);
        moving = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            step();
        end
        check("hold_anim", anim_frame, 1);
        check("hold_addr", rom_addr, 1024);

        tank_x = 10'd630;
        tick();
        draw_x = 10'd635;
        step();
        check("x630_hit", rom_addr, 1029);
        step(2);
        check("x630_on", sprite_on, 1);
        draw_x = 10'd5;
        step();
        check("x630_wrap", rom_addr, 0);
        step(2);
        check("x630_wrap_on", sprite_on, 0);

        tank_x = 10'd100;
        draw_x = 10'd635;
        step(3);
        check("midframe_hold", rom_addr, 1029);
        check("midframe_on", sprite_on, 1);
        tick();
        check("midframe_new", rom_addr, 0);

        draw_x = 10'd100;
        step(3);
        check("pre_rst_on", sprite_on, 1);
        #1 rst = 1'b1;
        #1;
        check("async_index", index, 0);
        check("async_on", sprite_on, 0);
        check("async_anim", anim_frame, 0);
        check("async_addr", rom_addr, 0);
        step();
        rst = 1'b0;
        draw_x = 10'd3;
        draw_y = 10'd5;
        step();
        check("post_rst_addr", rom_addr, 163);
        step(2);
        check("post_rst_on", sprite_on, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
